// File: rtl/kbd_message_scheduler.sv
// Keyboard line-edit buffer and line sender.
// Collects decoded keystrokes into a MAX_CHARS-deep buffer with backspace,
// then streams the line to the laser transmitter over valid/ready on enter.
// The buffer is locked while a line is being sent or cleared; keystrokes
// arriving in that window are discarded and reported through a sticky flag.

// One buffer slot. It resets or clears to the pad character and loads on a write strobe.
module kbd_slot #(
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic       clock_65mhz,
  input  logic       reset,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [7:0] q
);

  // Slot storage: the pad character on reset or clear, otherwise load on write.
  always_ff @(posedge clock_65mhz) begin
    if (!reset || clr) q <= PAD_CHAR;
    else if (wr_en)    q <= wr_data;
  end

endmodule

module kbd_message_scheduler #(
  parameter int         MAX_CHARS = 16,
  parameter logic [7:0] PAD_CHAR  = 8'h20,
  parameter logic [7:0] CR_CHAR   = 8'h0D,
  parameter logic [7:0] BS_CHAR   = 8'h08
) (
  input  logic                   clock_65mhz,
  input  logic                   reset,
  input  logic [7:0]             ascii,
  input  logic                   ascii_ready,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  output logic                   tx_last,
  output logic [8*MAX_CHARS-1:0] cstring,
  output logic [4:0]             length,
  output logic                   busy,
  output logic                   dropped
);

  localparam int         IW      = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam logic [4:0] MAX_LEN = 5'(MAX_CHARS);

  localparam logic [1:0] ST_EDIT  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]                 state;
  logic [IW-1:0]              idx;
  logic [IW-1:0]              nxt_idx;
  logic [IW-1:0]              del_pos;
  logic [IW-1:0]              ins_pos;
  logic [MAX_CHARS-1:0][7:0]  slot;
  logic [MAX_CHARS-1:0]       wr_en;
  logic [7:0]                 wr_data;
  logic                       in_edit;
  logic                       clr;
  logic                       key_bs;
  logic                       key_cr;
  logic                       key_chr;
  logic                       full;
  logic                       hs;

  assign in_edit = (state == ST_EDIT);
  assign clr     = (state == ST_CLEAR);
  assign key_bs  = ascii_ready && in_edit && (ascii == BS_CHAR);
  assign key_cr  = ascii_ready && in_edit && (ascii == CR_CHAR);
  assign key_chr = ascii_ready && in_edit && (ascii != BS_CHAR) && (ascii != CR_CHAR);
  assign full    = (length == MAX_LEN);
  assign hs      = tx_valid && tx_ready;
  assign nxt_idx = idx + 1'b1;

  // Backspace overwrites the last occupied slot with the pad character, a
  // printable key fills the first free one; position truncation is harmless
  // because the length guards below gate the write.
  assign del_pos = IW'(length - 5'd1);
  assign ins_pos = IW'(length);
  assign wr_data = key_bs ? PAD_CHAR : ascii;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_CHARS; gi++) begin : g_slot
      assign wr_en[gi] = (key_bs  && (length != 5'd0) && (del_pos == IW'(gi))) ||
                         (key_chr && !full           && (ins_pos == IW'(gi)));

      kbd_slot #(.PAD_CHAR(PAD_CHAR)) u_slot (
        .clock_65mhz (clock_65mhz),
        .reset       (reset),
        .clr         (clr),
        .wr_en       (wr_en[gi]),
        .wr_data     (wr_data),
        .q           (slot[gi])
      );

      // Slot 0 occupies the most significant byte so the display reads left to right.
      assign cstring[8*(MAX_CHARS-gi)-1 -: 8] = slot[gi];
    end
  endgenerate

  // Character count: tracks edits, frozen during a send, zeroed by the clear cycle.
  always_ff @(posedge clock_65mhz) begin
    if (!reset)                             length <= 5'd0;
    else if (clr)                           length <= 5'd0;
    else if (key_bs && length != 5'd0)      length <= length - 5'd1;
    else if (key_chr && !full)              length <= length + 5'd1;
  end

  // Sticky drop flag: set by keystrokes while locked or on a full buffer.
  always_ff @(posedge clock_65mhz) begin
    if (!reset)                          dropped <= 1'b0;
    else if (ascii_ready && !in_edit)    dropped <= 1'b1;
    else if (key_chr && full)            dropped <= 1'b1;
  end

  // Send sequencer: edit -> send (one byte per handshake) -> clear -> edit.
  always_ff @(posedge clock_65mhz) begin
    if (!reset) begin
      state    <= ST_EDIT;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_EDIT: begin
          if (key_cr && length != 5'd0) begin
            state    <= ST_SEND;
            idx      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= slot[0];
            tx_last  <= (length == 5'd1);
            busy     <= 1'b1;
          end
        end
        ST_SEND: begin
          // Without a handshake the presented byte simply holds.
          if (hs) begin
            if (tx_last) begin
              state    <= ST_CLEAR;
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              tx_last  <= 1'b0;
            end else begin
              idx     <= nxt_idx;
              tx_data <= slot[nxt_idx];
              tx_last <= (5'(nxt_idx) == length - 5'd1);
            end
          end
        end
        ST_CLEAR: begin
          state <= ST_EDIT;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_EDIT;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/kbd_message_scheduler.md
Name: kbd_message_scheduler

Overview:
- Sits between the PS/2 ASCII decoder output (ascii, ascii_ready one-cycle pulse) and the laser transmitter byte interface.
- Holds a line-edit buffer of up to MAX_CHARS characters and applies backspace. On enter, it sequences the buffered line to the transmitter over a valid/ready handshake.
- Locks the buffer while a send is in progress and arbitrates keyboard input against the send: keystrokes arriving during a send are dropped and flagged.
- Exposes the live buffer as a packed string for the display.

Parameters:
MAX_CHARS, 16, buffer depth in characters (cstring width = 8*MAX_CHARS)
PAD_CHAR, 8'h20, fill value for empty slots
CR_CHAR, 8'h0D, ends the line and starts a send
BS_CHAR, 8'h08, deletes the last character

Ports:
clock_65mhz  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low (0 = reset)
ascii  input  8  decoded character, valid only when ascii_ready=1
ascii_ready  input  1  one-cycle character strobe
tx_ready  input  1  transmitter accepts tx_data this cycle
tx_valid  output  1  tx_data/tx_last valid
tx_data  output  8  outgoing character
tx_last  output  1  marks final character of the line
cstring  output  8*MAX_CHARS  buffer image; slot 0 at [8*MAX_CHARS-1 -: 8], slot i at [8*(MAX_CHARS-i)-1 -: 8]
length  output  5  number of characters held, 0..MAX_CHARS
busy  output  1  1 in SEND or CLEAR
dropped  output  1  sticky: a keystroke was discarded

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to EDIT.
  - tx_valid=0, tx_data=0, tx_last=0, length=0, busy=0, dropped=0.
  - Every cstring slot = PAD_CHAR.
  - Reset during SEND aborts the line: tx_valid is low after that edge and the buffer is cleared.
- States are EDIT, SEND, CLEAR. All outputs are registered.
- EDIT, when ascii_ready=1:
  - ascii==BS_CHAR:
    - length>0: slot[length-1] becomes PAD_CHAR and length decrements.
    - length==0: no change.
  - ascii==CR_CHAR:
    - length>0: idx=0, go to SEND, and tx_valid=1 with tx_data=slot[0] on the next cycle.
    - length==0: ignored, no transmit.
  - Any other ascii:
    - length<MAX_CHARS: slot[length] becomes ascii and length increments.
    - length==MAX_CHARS: character discarded and dropped is set to 1.
  - Latency: cstring and length reflect a keystroke 1 cycle after the strobe.
- SEND:
  - tx_valid=1, tx_data=slot[idx], tx_last=(idx==length-1).
  - tx_data and tx_last hold stable while tx_valid=1 and tx_ready=0; tx_ready may stay low indefinitely.
  - Handshake occurs on a cycle with tx_valid&tx_ready:
    - tx_last=0: idx increments and the next character is presented the following cycle (supports 1 byte/cycle with tx_ready held high).
    - tx_last=1: tx_valid=0 next cycle and go to CLEAR.
  - Buffer contents and length are frozen.
- CLEAR: one cycle. All slots become PAD_CHAR, length=0, then go to EDIT. tx_valid=0.
- Keystroke arbitration: any ascii_ready in SEND or CLEAR is discarded and sets dropped. This includes a strobe in the same cycle as the final handshake; the send always has priority.
- dropped is cleared only by reset.
- busy=1 exactly while state is SEND or CLEAR.
- CR_CHAR and BS_CHAR are never stored or transmitted.
- Minimum line length is 1; a line of MAX_CHARS transmits MAX_CHARS bytes.

Test Plan:
- Reset then strobe 'H'(8'h48), 'I'(8'h49) -> length=2; cstring top bytes 48,49; remaining 14 slots 20; busy=0.
- 'A','B', BS, BS, BS -> length 2,1,0,0; third BS changes nothing; cstring all 8'h20.
- "HI" then CR with tx_ready=1 -> tx_valid cycles: 48 (last=0), then 49 (last=1). Next cycle: tx_valid=0, busy=1 (CLEAR). Following cycle: length=0, busy=0.
- "OK" then CR with tx_ready low for 5 cycles -> tx_data holds 8'h4F with tx_last=0 for 5 cycles. Release tx_ready -> 4F then 4B, in order.
- 17 printable strobes -> length=16, 17th char absent, dropped=1. CR then transmits exactly 16 bytes with tx_last on the 16th.
- CR with length=0 -> no tx_valid.
- Strobe 'X' during SEND, and again on the final-handshake cycle -> X not in buffer after send, dropped=1.
- Assert reset=0 mid-SEND -> tx_valid=0, length=0, dropped=0 after the edge.
